calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
//  Top-level operation controller for the matrix calculator. Accepts one operation request,
//  drives the operand selector (start/done/error handshake), then launches the compute unit
//  with the chosen matrix IDs and reports completion or a coded failure to the UI/display.
//  Sits between the UI front-end, operand_selector-style selector and the matrix ALU.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  max cycles waited for sel_done/sel_error or alu_done before abort
//  TO_W            16     width of timeout counter; TIMEOUT_CYCLES < 2**TO_W
//  MAX_RETRY       3      random-mode selection retries (only with CALC_SEQ_RETRY_EN)
// PORTS
//  clk         in   1  clock
//  rst_n       in   1  asynchronous, active-low reset
//  op_start    in   1  request pulse from UI; accepted only in IDLE
//  manual_mode in   1  1=manual IDs, 0=random IDs; latched on accept
//  op_type     in   3  000 transpose,001 add,010 scalar,011 multiply,100 conv; latched
//  sel_start   out  1  one-cycle pulse to selector (start or clear)
//  sel_mode    out  1  latched manual_mode forwarded to selector
//  sel_op      out  3  latched op_type forwarded to selector
//  sel_done    in   1  selector success pulse; sel_a/sel_b valid same cycle
//  sel_error   in   1  selector failure (level)
//  sel_a,sel_b in   4  selected matrix IDs
//  alu_start   out  1  one-cycle pulse launching compute
//  alu_op      out  3  latched op_type; alu_id_a/alu_id_b out 4 each: captured IDs
//  alu_done    in   1  compute completion pulse
//  busy        out  1  high whenever state != IDLE
//  op_done     out  1  one-cycle success pulse
//  op_error    out  1  held high from failure until next accepted op_start
//  err_code    out  2  01 invalid selection, 10 select timeout, 11 exec timeout; 00 otherwise
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, counters 0. Reset mid-operation aborts with no pulses.
//  - All outputs registered. States: IDLE, SEL_REQ, SEL_WAIT, SEL_CLR, EXEC_REQ, EXEC_WAIT, DONE, FAIL.
//  - IDLE: op_start -> latch mode/op, clear op_error/err_code, retry_cnt=0 -> SEL_REQ. op_start
//    outside IDLE ignored (no queueing).
//  - SEL_REQ: sel_start=1 one cycle (cycle after op_start accept) -> SEL_WAIT, timer=0.
//  - SEL_WAIT: sel_error wins over sel_done if same cycle. sel_done -> capture sel_a/sel_b into
//    alu_id_a/b -> EXEC_REQ. sel_error -> err_code=01 -> SEL_CLR. timer==TIMEOUT_CYCLES-1 with
//    neither -> err_code=10 -> SEL_CLR. Inputs sampled only in SEL_WAIT.
//  - SEL_CLR: sel_start=1 one cycle (returns selector from ERROR to IDLE), then one gap cycle
//    with sel_start=0, then FAIL (or SEL_REQ if retrying, see CONFIGURATION).
//  - EXEC_REQ: alu_start=1 one cycle -> EXEC_WAIT, timer=0. alu_done ignored outside EXEC_WAIT.
//  - EXEC_WAIT: alu_done -> DONE; timeout -> err_code=11 -> FAIL (no selector clear needed).
//  - DONE: op_done=1 one cycle -> IDLE. FAIL: op_error=1 (held) -> IDLE same cycle after.
//  - Timer saturates at TIMEOUT_CYCLES-1; never wraps. Best-case latency op_start->alu_start:
//    3 cycles + selector latency.
// CONFIGURATION
//  CALC_SEQ_RETRY_EN defined: in random mode (latched manual_mode=0), a sel_error (not a
//   timeout) with retry_cnt<MAX_RETRY increments retry_cnt and SEL_CLR returns to SEL_REQ
//   instead of FAIL; err_code stays 00 until retries exhausted. Manual mode never retries.
//  Not defined: every selection failure goes to FAIL immediately; retry_cnt logic absent.
// STRUCTURE
//  calc_pkg: op_type codes, err_code values, state encoding localparams.
//  Sub-module calc_timeout_timer (clear, enable, expired flag); two instances not needed,
//  one shared instance cleared on entry to SEL_WAIT and EXEC_WAIT.
// TESTING
//  1 Manual add, sel_done after 2 cycles, alu_done after 5 -> ids forwarded, op_done pulse, err_code 00.
//  2 Manual multiply, sel_error -> sel_start clear pulse, op_error=1, err_code=01, busy drops.
//  3 Selector silent for TIMEOUT_CYCLES -> err_code=10; ALU silent -> err_code=11.
//  4 With CALC_SEQ_RETRY_EN, random mode, 2 sel_errors then sel_done -> 3 start pulses, op_done.
//  5 sel_done and sel_error same cycle -> treated as error; op_start while busy -> ignored.
//  6 rst_n asserted in EXEC_WAIT -> all outputs 0 immediately, next op_start runs normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the matrix-calculator operation sequencer:
// op_type codes, err_code values and the sequencer state type.
package calc_pkg;

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALAR    = 3'b010;
  localparam logic [2:0] OP_MULTIPLY  = 3'b011;
  localparam logic [2:0] OP_CONV      = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_SEL_TO  = 2'b10;
  localparam logic [1:0] ERR_EXEC_TO = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSelReq,
    StSelWait,
    StSelClr,
    StExecReq,
    StExecWait,
    StDone,
    StFail
  } state_t;

endpackage

// File: rtl/calc_timeout_timer.sv
// Saturating wait timer: cleared the cycle before a wait state, counts while enabled,
// flags expiry once it reaches TIMEOUT_CYCLES-1.
module calc_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LastCount = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LastCount)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LastCount);

endmodule

// File: rtl/calc_op_sequencer.sv
// Operation controller: selector handshake, ALU launch, completion/error reporting.
// Optional feature: define CALC_SEQ_RETRY_EN to retry random-mode selection failures.
module calc_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
`ifdef CALC_SEQ_RETRY_EN
  , parameter int unsigned MAX_RETRY    = 3
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_start,
  input  logic       manual_mode,
  input  logic [2:0] op_type,
  output logic       sel_start,
  output logic       sel_mode,
  output logic [2:0] sel_op,
  input  logic       sel_done,
  input  logic       sel_error,
  input  logic [3:0] sel_a,
  input  logic [3:0] sel_b,
  output logic       alu_start,
  output logic [2:0] alu_op,
  output logic [3:0] alu_id_a,
  output logic [3:0] alu_id_b,
  input  logic       alu_done,
  output logic       busy,
  output logic       op_done,
  output logic       op_error,
  output logic [1:0] err_code
);
  import calc_pkg::*;

  state_t     r_state;
  logic       r_sel_start, r_sel_mode, r_alu_start, r_busy, r_op_done, r_op_error;
  logic [2:0] r_sel_op, r_alu_op;
  logic [3:0] r_alu_id_a, r_alu_id_b;
  logic [1:0] r_err_code;
  logic       r_clr_gap;
  logic       w_expired, w_timer_clear, w_timer_en, w_retry_now;

  assign w_timer_clear = (r_state == StSelReq) || (r_state == StExecReq);
  assign w_timer_en    = (r_state == StSelWait) || (r_state == StExecWait);

  calc_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

`ifdef CALC_SEQ_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry_cnt;

  // Only selector-reported errors in random mode are retried, never timeouts.
  assign w_retry_now = (r_state == StSelWait) && sel_error && !r_sel_mode &&
                       (r_retry_cnt < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry_cnt <= '0;
    end else if ((r_state == StIdle) && op_start) begin
      r_retry_cnt <= '0;
    end else if (w_retry_now) begin
      r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end
`else
  assign w_retry_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel_start <= 1'b0;
      r_sel_mode  <= 1'b0;
      r_sel_op    <= 3'b000;
      r_alu_start <= 1'b0;
      r_alu_op    <= 3'b000;
      r_alu_id_a  <= 4'h0;
      r_alu_id_b  <= 4'h0;
      r_busy      <= 1'b0;
      r_op_done   <= 1'b0;
      r_op_error  <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_clr_gap   <= 1'b0;
    end else begin
      r_sel_start <= 1'b0;
      r_alu_start <= 1'b0;
      r_op_done   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (op_start) begin
            r_state     <= StSelReq;
            r_sel_start <= 1'b1;
            r_sel_mode  <= manual_mode;
            r_sel_op    <= op_type;
            r_alu_op    <= op_type;
            r_op_error  <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_busy      <= 1'b1;
          end
        end
        StSelReq: r_state <= StSelWait;
        StSelWait: begin
          if (sel_error) begin
            r_state     <= StSelClr;
            r_sel_start <= 1'b1;
            r_clr_gap   <= 1'b0;
            if (!w_retry_now) r_err_code <= ERR_INVALID;
          end else if (sel_done) begin
            r_state     <= StExecReq;
            r_alu_start <= 1'b1;
            r_alu_id_a  <= sel_a;
            r_alu_id_b  <= sel_b;
          end else if (w_expired) begin
            r_state     <= StSelClr;
            r_sel_start <= 1'b1;
            r_clr_gap   <= 1'b0;
            r_err_code  <= ERR_SEL_TO;
          end
        end
        StSelClr: begin
          // Clear pulse, then a gap cycle; a still-clean err_code marks a pending retry.
          if (!r_clr_gap) begin
            r_clr_gap <= 1'b1;
          end else if (r_err_code == ERR_NONE) begin
            r_state     <= StSelReq;
            r_sel_start <= 1'b1;
          end else begin
            r_state    <= StFail;
            r_op_error <= 1'b1;
          end
        end
        StExecReq: r_state <= StExecWait;
        StExecWait: begin
          if (alu_done) begin
            r_state   <= StDone;
            r_op_done <= 1'b1;
          end else if (w_expired) begin
            r_state    <= StFail;
            r_op_error <= 1'b1;
            r_err_code <= ERR_EXEC_TO;
          end
        end
        StDone, StFail: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_start = r_sel_start;
  assign sel_mode  = r_sel_mode;
  assign sel_op    = r_sel_op;
  assign alu_start = r_alu_start;
  assign alu_op    = r_alu_op;
  assign alu_id_a  = r_alu_id_a;
  assign alu_id_b  = r_alu_id_b;
  assign busy      = r_busy;
  assign op_done   = r_op_done;
  assign op_error  = r_op_error;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a short timeout; status vector is
// {busy, sel_start, alu_start, op_done, op_error, err_code}.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_start, manual_mode, sel_done, sel_error, alu_done;
  logic [2:0] op_type;
  logic [3:0] sel_a, sel_b;
  logic       sel_start, sel_mode, alu_start, busy, op_done, op_error;
  logic [2:0] sel_op, alu_op;
  logic [3:0] alu_id_a, alu_id_b;
  logic [1:0] err_code;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0]  obs, exp_v;
  logic [14:0] dat, exp_d;

  assign obs = {busy, sel_start, alu_start, op_done, op_error, err_code};
  assign dat = {sel_mode, sel_op, alu_op, alu_id_a, alu_id_b};

  always #5 clk = ~clk;

  calc_op_sequencer #(
    .TIMEOUT_CYCLES(20),
    .TO_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_start   (op_start),
    .manual_mode(manual_mode),
    .op_type    (op_type),
    .sel_start  (sel_start),
    .sel_mode   (sel_mode),
    .sel_op     (sel_op),
    .sel_done   (sel_done),
    .sel_error  (sel_error),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_id_a   (alu_id_a),
    .alu_id_b   (alu_id_b),
    .alu_done   (alu_done),
    .busy       (busy),
    .op_done    (op_done),
    .op_error   (op_error),
    .err_code   (err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_start = 0; manual_mode = 0; op_type = 3'b000;
    sel_done = 0; sel_error = 0; sel_a = 4'h0; sel_b = 4'h0; alu_done = 0;
    tick(); tick();
    exp_v = 7'b0000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_status got %b want %b", obs, exp_v); end
    exp_d = 15'h0; n_chk++;
    if (dat !== exp_d) begin n_fail++; $display("FAIL reset_data got %h want %h", dat, exp_d); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual_add();
    op_start = 1; manual_mode = 1; op_type = 3'b001;
    tick();
    exp_v = 7'b1100000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_selreq got %b want %b", obs, exp_v); end
    exp_d = {1'b1, 3'b001, 3'b001, 4'h0, 4'h0}; n_chk++;
    if (dat !== exp_d) begin n_fail++; $display("FAIL add_latch got %h want %h", dat, exp_d); end
    op_start = 0;
    tick();
    exp_v = 7'b1000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_selwait got %b want %b", obs, exp_v); end
    tick();
    sel_done = 1; sel_a = 4'd3; sel_b = 4'd5;
    tick();
    exp_v = 7'b1010000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_execreq got %b want %b", obs, exp_v); end
    exp_d = {1'b1, 3'b001, 3'b001, 4'd3, 4'd5}; n_chk++;
    if (dat !== exp_d) begin n_fail++; $display("FAIL add_ids got %h want %h", dat, exp_d); end
    sel_done = 0; sel_a = 4'h0; sel_b = 4'h0;
    op_start = 1;  // must be ignored while busy
    repeat (4) tick();
    exp_v = 7'b1000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_busy_ign got %b want %b", obs, exp_v); end
    op_start = 0; alu_done = 1;
    tick();
    exp_v = 7'b1001000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_done got %b want %b", obs, exp_v); end
    alu_done = 0;
    tick();
    exp_v = 7'b0000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_idle got %b want %b", obs, exp_v); end
    tick();
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL add_noqueue got %b want %b", obs, exp_v); end
  endtask

  task automatic test_sel_error();
    op_start = 1; manual_mode = 1; op_type = 3'b011;
    tick();
    op_start = 0;
    tick();
    sel_error = 1;
    tick();
    exp_v = 7'b1100001; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL err_clr got %b want %b", obs, exp_v); end
    sel_error = 0;
    tick();
    exp_v = 7'b1000001; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL err_gap got %b want %b", obs, exp_v); end
    tick();
    exp_v = 7'b1000101; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL err_fail got %b want %b", obs, exp_v); end
    tick();
    exp_v = 7'b0000101; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL err_idle got %b want %b", obs, exp_v); end
  endtask

  task automatic test_timeouts();
    op_start = 1; manual_mode = 1; op_type = 3'b000;
    tick();
    exp_v = 7'b1100000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL to_clear_err got %b want %b", obs, exp_v); end
    op_start = 0;
    tick();
    repeat (19) tick();
    exp_v = 7'b1000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sel_to_early got %b want %b", obs, exp_v); end
    tick();
    exp_v = 7'b1100010; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sel_to_clr got %b want %b", obs, exp_v); end
    tick(); tick(); tick();
    exp_v = 7'b0000110; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL sel_to_idle got %b want %b", obs, exp_v); end
    op_start = 1; op_type = 3'b100;
    tick();
    op_start = 0;
    tick();
    sel_done = 1; sel_a = 4'd1; sel_b = 4'd2;
    tick();
    sel_done = 0; alu_done = 1;  // alu_done during EXEC_REQ is ignored
    tick();
    alu_done = 0;
    repeat (19) tick();
    exp_v = 7'b1000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL exe_to_early got %b want %b", obs, exp_v); end
    tick();
    exp_v = 7'b1000111; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL exe_to_fail got %b want %b", obs, exp_v); end
    tick();
    exp_v = 7'b0000111; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL exe_to_idle got %b want %b", obs, exp_v); end
  endtask

  task automatic test_same_cycle();
    op_start = 1; manual_mode = 1; op_type = 3'b010;
    tick();
    tick();
    exp_v = 7'b1000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL same_wait got %b want %b", obs, exp_v); end
    op_start = 0; sel_done = 1; sel_error = 1; sel_a = 4'd6; sel_b = 4'd7;
    tick();
    exp_v = 7'b1100001; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL same_err got %b want %b", obs, exp_v); end
    sel_done = 0; sel_error = 0;
    tick(); tick(); tick();
    exp_v = 7'b0000101; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL same_idle got %b want %b", obs, exp_v); end
  endtask

  task automatic test_random_mode();
    op_start = 1; manual_mode = 0; op_type = 3'b001;
    tick();
    op_start = 0;
    tick();
`ifdef CALC_SEQ_RETRY_EN
    for (int k = 0; k < 2; k++) begin
      sel_error = 1;
      tick();
      exp_v = 7'b1100000; n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL retry_clr got %b want %b", obs, exp_v); end
      sel_error = 0;
      tick(); tick();
      exp_v = 7'b1100000; n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL retry_req got %b want %b", obs, exp_v); end
      tick();
    end
    sel_done = 1; sel_a = 4'd7; sel_b = 4'd9;
    tick();
    exp_v = 7'b1010000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL retry_exec got %b want %b", obs, exp_v); end
    sel_done = 0;
    tick();
    alu_done = 1;
    tick();
    exp_v = 7'b1001000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL retry_done got %b want %b", obs, exp_v); end
    alu_done = 0;
    tick();
`else
    sel_error = 1;
    tick();
    exp_v = 7'b1100001; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rand_clr got %b want %b", obs, exp_v); end
    sel_error = 0;
    tick(); tick();
    exp_v = 7'b1000101; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rand_fail got %b want %b", obs, exp_v); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_exec();
    op_start = 1; manual_mode = 1; op_type = 3'b001;
    tick();
    op_start = 0;
    tick();
    sel_done = 1; sel_a = 4'd4; sel_b = 4'd6;
    tick();
    sel_done = 0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_v = 7'b0000000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rst_status got %b want %b", obs, exp_v); end
    exp_d = 15'h0; n_chk++;
    if (dat !== exp_d) begin n_fail++; $display("FAIL rst_data got %h want %h", dat, exp_d); end
    tick();
    rst_n = 1'b1;
    tick();
    op_start = 1; op_type = 3'b011;
    tick();
    exp_v = 7'b1100000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_rst_req got %b want %b", obs, exp_v); end
    op_start = 0;
    tick();
    sel_done = 1; sel_a = 4'd2; sel_b = 4'd8;
    tick();
    exp_d = {1'b1, 3'b011, 3'b011, 4'd2, 4'd8}; n_chk++;
    if (dat !== exp_d) begin n_fail++; $display("FAIL post_rst_ids got %h want %h", dat, exp_d); end
    sel_done = 0;
    tick();
    alu_done = 1;
    tick();
    exp_v = 7'b1001000; n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_rst_done got %b want %b", obs, exp_v); end
    alu_done = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_manual_add();
    test_sel_error();
    test_timeouts();
    test_same_cycle();
    test_random_mode();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
